mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port arbiter that shares the single-port, word-organised unified memory between the core's instruction-fetch unit and its load/store unit. It issues at most one access per cycle and gives data accesses priority, with a bounded-streak rule so fetch cannot starve. It checks alignment before issue and routes each registered read response back to the port that was granted. It sits between the core pipeline and the memory block.

## Interface
- STREAK_MAX, 4: maximum consecutive data grants while a fetch is pending; the next grant goes to fetch (range 1-15).
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- if_req  in  1  fetch request; held until if_gnt
- if_addr  in  32  fetch byte address; always a word read
- if_gnt  out  1  fetch accepted this cycle (combinational)
- if_rvalid  out  1  fetch response valid
- if_rdata  out  32  fetched word
- if_err  out  1  with if_rvalid: fetch was misaligned and not issued
- d_req  in  1  data request; held stable until d_gnt
- d_rw  in  1  1 = store, 0 = load
- d_func  in  3  bits [1:0]: 00 byte, 01 half, 10 word; bit 2 = unsigned load
- d_addr  in  32  data byte address
- d_wdata  in  32  store data, right-aligned
- d_gnt  out  1  data request accepted this cycle (combinational)
- d_rvalid  out  1  data response valid, for loads and stores
- d_rdata  out  32  load result; 0 for stores and errors
- d_err  out  1  with d_rvalid: data access was misaligned and not issued
- mem_rw, mem_func[2:0], mem_addr[31:0], mem_wdata[31:0]  out  memory command
- mem_rdata  in  32  registered memory read data

## Operation
- **Arbitration.** Evaluated each cycle that reset is low.
  - Only one of if_req or d_req asserted: that requester is granted.
  - Both asserted: d wins, unless streak == STREAK_MAX, in which case if wins.
- **Streak counter (4 bits).**
  - Increments on each d grant while if_req is high.
  - Clears on any if grant, and on any cycle where if_req is low.
  - Saturates at STREAK_MAX.
- **Alignment rules.** Misaligned cases:
  - half with addr[0] = 1;
  - word with addr[1:0] != 0;
  - fetch with if_addr[1:0] != 0.
  - A misaligned request is still granted and consumes the slot, but the memory command is idle: mem_rw = 0 and the store is suppressed. The response carries err = 1 and rdata = 0.
- **Memory command.**
  - Granted, aligned access: mem_* are driven combinationally from the winner. Fetch uses mem_rw = 0 and mem_func = 3'b010.
  - No grant: mem_rw = 0, mem_func = 3'b010, mem_addr = 0, mem_wdata = 0.
- **Response tracking.** Registered one-entry tag {valid, port, is_store, err}, captured at each grant.
  - In the next cycle, the tagged port's rvalid pulses for one cycle.
  - rdata = mem_rdata for an aligned load or fetch, and 0 otherwise.
  - Responses cannot be back-pressured; requesters must accept them.

## Timing
- Grant in cycle N. The memory samples the command at the end of N. rvalid and rdata are presented in cycle N+1.
- Full throughput: a new grant is allowed every cycle, including to the same port, while the previous response is being returned.
- Store in N followed by a load of the same word in N+1 returns the new data in N+2.
- **Reset.**
  - While reset is high: if_gnt = d_gnt = 0, mem_rw = 0, streak cleared, tag cleared.
  - All rvalid and err outputs are 0 during reset and in the first cycle after it.
  - Reset asserted in the cycle after a grant suppresses that response; the requester must reissue.
- A request dropped before its grant is a protocol violation with undefined behaviour; the bench asserts against it.

## Structure
- **Package mem_arb_pkg:**
  - FUNC_B = 3'b000, FUNC_H = 3'b001, FUNC_W = 3'b010, FUNC_BU = 3'b100, FUNC_HU = 3'b101;
  - grant enum {GNT_NONE, GNT_IF, GNT_D};
  - misaligned(func, addr) function.
- **Sub-modules:** no sub-module. The arbitration logic, streak counter and response tag stay in one module of about 150-200 lines.

## Test plan
- **Fetch only:** if_req with if_addr = 0x100 and mem[0x40] = 0x00000013 -> if_gnt in cycle 0; if_rvalid = 1, if_rdata = 0x00000013, if_err = 0 in cycle 1.
- **Contention:**
  - Stimulus: if_req and d_req (load word from 0x200) held high continuously, STREAK_MAX = 4.
  - Required grant sequence: d, d, d, d, if, d, d, d, d, if.
  - Each response arrives one cycle after its grant, on the correct port.
- **Store then load:** d store half, wdata = 0xBEEF, addr 0x302, then d load half signed at 0x302 -> store response d_rvalid = 1, d_rdata = 0; load response d_rdata = 0xFFFFBEEF.
- **Misaligned:**
  - Word store to 0x201 -> d_gnt = 1 and mem_rw = 0 in that cycle; next cycle d_rvalid = 1, d_err = 1, d_rdata = 0.
  - A following load of 0x200 returns the unchanged contents.
- **Reset mid-operation:** grant a load in cycle N, assert reset in N+1 -> d_rvalid = 0 in N+1 and N+2; streak = 0; no grant until the cycle after reset deasserts.
- **Idle:** no requests for 10 cycles -> mem_rw = 0, mem_addr = 0, all rvalid = 0, streak remains 0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared access codes, grant type and
// alignment helper for the unified-memory arbiter.
package mem_arb_pkg;

  localparam logic [2:0] FUNC_B  = 3'b000;
  localparam logic [2:0] FUNC_H  = 3'b001;
  localparam logic [2:0] FUNC_W  = 3'b010;
  localparam logic [2:0] FUNC_BU = 3'b100;
  localparam logic [2:0] FUNC_HU = 3'b101;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_IF,
    GNT_D
  } grant_e;

  typedef struct packed {
    logic valid;
    logic port_d;
    logic is_store;
    logic err;
  } rsp_tag_t;

  // Only the low address bits matter for alignment.
  function automatic logic misaligned(
    input logic [2:0] func,
    input logic [1:0] addr
  );
    logic r;
    r = 1'b0;
    case (func)
      FUNC_H, FUNC_HU: r = addr[0];
      FUNC_W:          r = |addr;
      default:         r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single-port memory between
// fetch and load/store, data first with a streak cap.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned STREAK_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  output logic        if_err,
  input  logic        d_req,
  input  logic        d_rw,
  input  logic [2:0]  d_func,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic        mem_rw,
  output logic [2:0]  mem_func,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [3:0] LP_SMAX = 4'(STREAK_MAX);

  logic [3:0] r_streak;
  rsp_tag_t   r_tag;
  grant_e     w_gnt;
  logic       w_if_mis;
  logic       w_d_mis;
  logic       w_rsp;

  assign w_if_mis = misaligned(FUNC_W, if_addr[1:0]);
  assign w_d_mis  = misaligned(d_func, d_addr[1:0]);

  // Pick this cycle's winner; fetch wins once the streak is full.
  always_comb begin
    w_gnt = GNT_NONE;
    if (!reset) begin
      if (d_req && (!if_req || r_streak != LP_SMAX)) begin
        w_gnt = GNT_D;
      end else if (if_req) begin
        w_gnt = GNT_IF;
      end
    end
  end

  assign if_gnt = (w_gnt == GNT_IF);
  assign d_gnt  = (w_gnt == GNT_D);

  // Drive the memory command from the winner; misaligned stays idle.
  always_comb begin
    mem_rw    = 1'b0;
    mem_func  = FUNC_W;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (w_gnt)
      GNT_IF: begin
        if (!w_if_mis) begin
          mem_addr = if_addr;
        end
      end
      GNT_D: begin
        if (!w_d_mis) begin
          mem_rw    = d_rw;
          mem_func  = d_func;
          mem_addr  = d_addr;
          mem_wdata = d_wdata;
        end
      end
      default: ;
    endcase
  end

  // Count data grants that happen while a fetch is waiting.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_streak <= '0;
    end else if (!if_req || w_gnt == GNT_IF) begin
      r_streak <= '0;
    end else if (w_gnt == GNT_D && r_streak != LP_SMAX) begin
      r_streak <= r_streak + 4'd1;
    end
  end

  // Remember who was granted so the response is routed next cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tag <= '0;
    end else begin
      r_tag.valid    <= (w_gnt != GNT_NONE);
      r_tag.port_d   <= (w_gnt == GNT_D);
      r_tag.is_store <= (w_gnt == GNT_D) && d_rw;
      r_tag.err      <= ((w_gnt == GNT_IF) && w_if_mis) ||
                        ((w_gnt == GNT_D) && w_d_mis);
    end
  end

  assign w_rsp = r_tag.valid && !reset;

  assign if_rvalid = w_rsp && !r_tag.port_d;
  assign if_err    = if_rvalid && r_tag.err;
  assign if_rdata  = (if_rvalid && !r_tag.err) ? mem_rdata : '0;

  assign d_rvalid = w_rsp && r_tag.port_d;
  assign d_err    = d_rvalid && r_tag.err;
  assign d_rdata  = (d_rvalid && !r_tag.err && !r_tag.is_store)
                    ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus random traffic
// checked against a byte-level reference of the memory.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int SMAX = 4;
  localparam int NRND = 400;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_gnt, if_rvalid, if_err;
  logic [31:0] if_rdata;
  logic        d_req = 1'b0;
  logic        d_rw = 1'b0;
  logic [2:0]  d_func = 3'b010;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic        d_gnt, d_rvalid, d_err;
  logic [31:0] d_rdata;
  logic        mem_rw;
  logic [2:0]  mem_func;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;

  int checks = 0;
  int errors = 0;

  logic [31:0] dev_word [1024];
  logic [7:0]  ref_mem  [4096];

  mem_arbiter #(.STREAK_MAX(SMAX)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
    .d_req(d_req), .d_rw(d_rw), .d_func(d_func),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_rw(mem_rw), .mem_func(mem_func), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Word-organised memory with registered, extended read data.
  always @(posedge clk) begin
    logic [31:0] w;
    logic [31:0] s;
    w = dev_word[mem_addr[11:2]];
    if (mem_rw) begin
      case (mem_func[1:0])
        2'b00:   w[8*mem_addr[1:0] +: 8] = mem_wdata[7:0];
        2'b01:   w[16*mem_addr[1] +: 16] = mem_wdata[15:0];
        default: w = mem_wdata;
      endcase
      dev_word[mem_addr[11:2]] = w;
    end
    s = w >> (8*mem_addr[1:0]);
    case (mem_func[1:0])
      2'b00: mem_rdata <= mem_func[2] ? {24'h0, s[7:0]}
                                      : {{24{s[7]}}, s[7:0]};
      2'b01: mem_rdata <= mem_func[2] ? {16'h0, s[15:0]}
                                      : {{16{s[15]}}, s[15:0]};
      default: mem_rdata <= w;
    endcase
  end

  // Requests must be held until granted.
  logic pv_d = 1'b0;
  logic pv_if = 1'b0;
  always @(posedge clk) begin
    if (!reset && pv_d)
      assert (d_req) else $error("protocol: data request dropped");
    if (!reset && pv_if)
      assert (if_req) else $error("protocol: fetch request dropped");
    pv_d  <= d_req && !d_gnt && !reset;
    pv_if <= if_req && !if_gnt && !reset;
  end

  function automatic logic [31:0] ref_load(
    input logic [31:0] a, input logic [2:0] f);
    logic [11:0] i;
    logic [7:0]  b;
    logic [15:0] h;
    i = a[11:0];
    b = ref_mem[i];
    h = {ref_mem[i + 12'd1], ref_mem[i]};
    case (f[1:0])
      2'b00:   return f[2] ? {24'h0, b} : {{24{b[7]}}, b};
      2'b01:   return f[2] ? {16'h0, h} : {{16{h[15]}}, h};
      default: return {ref_mem[i + 12'd3], ref_mem[i + 12'd2], h};
    endcase
  endfunction

  task automatic ref_store(
    input logic [31:0] a, input logic [2:0] f,
    input logic [31:0] wd);
    logic [11:0] i;
    i = a[11:0];
    ref_mem[i] = wd[7:0];
    if (f[1:0] != 2'b00) ref_mem[i + 12'd1] = wd[15:8];
    if (f[1:0] == 2'b10) begin
      ref_mem[i + 12'd2] = wd[23:16];
      ref_mem[i + 12'd3] = wd[31:24];
    end
  endtask

  function automatic logic ref_mis(
    input logic [2:0] f, input logic [31:0] a);
    if (f[1:0] == 2'b01) return a[0];
    if (f[1:0] == 2'b10) return a[1:0] != 2'b00;
    return 1'b0;
  endfunction

  task automatic poke(input logic [31:0] a, input logic [31:0] w);
    dev_word[a[11:2]] = w;
    ref_store({a[31:2], 2'b00}, FUNC_W, w);
  endtask

  task automatic set_idle();
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_rw = 1'b0; d_func = FUNC_W;
    d_addr = '0; d_wdata = '0;
  endtask

  task automatic d_cmd(input logic rw, input logic [2:0] f,
                       input logic [31:0] a, input logic [31:0] wd);
    d_req = 1'b1; d_rw = rw; d_func = f; d_addr = a; d_wdata = wd;
  endtask

  task automatic test_reset();
    if_req = 1'b1; d_cmd(1'b1, FUNC_W, 32'h0, 32'hFFFF_FFFF);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk); #1;
      checks++;
      if ({if_gnt, d_gnt, mem_rw, if_rvalid, d_rvalid, if_err, d_err}
          !== 7'b0) begin
        errors++;
        $display("FAIL reset_hold: got %b want 0",
          {if_gnt, d_gnt, mem_rw, if_rvalid, d_rvalid, if_err, d_err});
      end
    end
    @(negedge clk);
    reset = 1'b0; set_idle(); #1;
    checks++;
    if ({if_rvalid, d_rvalid, if_err, d_err} !== 4'b0) begin
      errors++;
      $display("FAIL reset_first: got %b want 0",
        {if_rvalid, d_rvalid, if_err, d_err});
    end
  endtask

  task automatic test_idle();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk); set_idle(); #1;
      checks++;
      if ({mem_rw, mem_addr, if_rvalid, d_rvalid, if_gnt, d_gnt}
          !== 37'b0) begin
        errors++;
        $display("FAIL idle c%0d: rw=%b addr=%h rv=%b%b gnt=%b%b",
          c, mem_rw, mem_addr, if_rvalid, d_rvalid, if_gnt, d_gnt);
      end
    end
  endtask

  task automatic test_fetch_only();
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h100; #1;
    checks++;
    if ({if_gnt, d_gnt, mem_rw, mem_func, mem_addr}
        !== {3'b100, FUNC_W, 32'h100}) begin
      errors++;
      $display("FAIL fetch_cmd: gnt=%b%b rw=%b func=%b addr=%h",
        if_gnt, d_gnt, mem_rw, mem_func, mem_addr);
    end
    @(negedge clk);
    set_idle(); #1;
    checks++;
    if ({if_rvalid, if_err, if_rdata, d_rvalid}
        !== {2'b10, 32'h13, 1'b0}) begin
      errors++;
      $display("FAIL fetch_rsp: rv=%b err=%b data=%h want 1 0 00000013",
        if_rvalid, if_err, if_rdata);
    end
  endtask

  task automatic test_contention();
    logic prev_if;
    logic want_if;
    poke(32'h200, 32'hCAFE_0001);
    prev_if = 1'b0;
    for (int i = 0; i <= 2 * (SMAX + 1); i++) begin
      @(negedge clk);
      if_req = (i < 2 * (SMAX + 1));
      if_addr = 32'h100;
      d_cmd(1'b0, FUNC_W, 32'h200, 32'h0);
      #1;
      want_if = (i < 2 * (SMAX + 1)) && (i % (SMAX + 1) == SMAX);
      checks++;
      if ({if_gnt, d_gnt} !== {want_if, !want_if}) begin
        errors++;
        $display("FAIL cont_gnt i=%0d: got %b%b want %b%b",
          i, if_gnt, d_gnt, want_if, !want_if);
      end
      if (i > 0) begin
        checks++;
        if ({if_rvalid, d_rvalid, if_rdata, d_rdata} !==
            (prev_if ? {2'b10, 32'h13, 32'h0}
                     : {2'b01, 32'h0, 32'hCAFE_0001})) begin
          errors++;
          $display("FAIL cont_rsp i=%0d: rv=%b%b if=%h d=%h prev_if=%b",
            i, if_rvalid, d_rvalid, if_rdata, d_rdata, prev_if);
        end
      end
      prev_if = want_if;
    end
    @(negedge clk);
    set_idle(); #1;
    checks++;
    if ({if_rvalid, d_rvalid, d_rdata} !== {2'b01, 32'hCAFE_0001}) begin
      errors++;
      $display("FAIL cont_last: rv=%b%b d=%h want 01 cafe0001",
        if_rvalid, d_rvalid, d_rdata);
    end
  endtask

  task automatic test_store_load();
    @(negedge clk);
    d_cmd(1'b1, FUNC_H, 32'h302, 32'h0000_BEEF); #1;
    checks++;
    if ({d_gnt, mem_rw, mem_func, mem_addr, mem_wdata}
        !== {2'b11, FUNC_H, 32'h302, 32'h0000_BEEF}) begin
      errors++;
      $display("FAIL st_cmd: gnt=%b rw=%b f=%b a=%h wd=%h",
        d_gnt, mem_rw, mem_func, mem_addr, mem_wdata);
    end
    ref_store(32'h302, FUNC_H, 32'h0000_BEEF);
    @(negedge clk);
    d_cmd(1'b0, FUNC_H, 32'h302, 32'h0); #1;
    checks++;
    if ({d_gnt, d_rvalid, d_err, d_rdata} !== {3'b110, 32'h0}) begin
      errors++;
      $display("FAIL st_rsp: gnt=%b rv=%b err=%b data=%h",
        d_gnt, d_rvalid, d_err, d_rdata);
    end
    @(negedge clk);
    set_idle(); #1;
    checks++;
    if ({d_rvalid, d_err, d_rdata} !== {2'b10, 32'hFFFF_BEEF}) begin
      errors++;
      $display("FAIL ld_rsp: rv=%b err=%b data=%h want ffffbeef",
        d_rvalid, d_err, d_rdata);
    end
  endtask

  task automatic test_misaligned();
    poke(32'h200, 32'h1122_3344);
    @(negedge clk);
    d_cmd(1'b1, FUNC_W, 32'h201, 32'h5566_7788); #1;
    checks++;
    if ({d_gnt, mem_rw} !== 2'b10) begin
      errors++;
      $display("FAIL mis_cmd: gnt=%b rw=%b want 1 0", d_gnt, mem_rw);
    end
    @(negedge clk);
    d_cmd(1'b0, FUNC_W, 32'h200, 32'h0); #1;
    checks++;
    if ({d_gnt, d_rvalid, d_err, d_rdata} !== {3'b111, 32'h0}) begin
      errors++;
      $display("FAIL mis_rsp: gnt=%b rv=%b err=%b data=%h",
        d_gnt, d_rvalid, d_err, d_rdata);
    end
    @(negedge clk);
    set_idle(); if_req = 1'b1; if_addr = 32'h102; #1;
    checks++;
    if ({d_rvalid, d_err, d_rdata} !== {2'b10, 32'h1122_3344}) begin
      errors++;
      $display("FAIL mis_after: rv=%b err=%b data=%h want 11223344",
        d_rvalid, d_err, d_rdata);
    end
    checks++;
    if ({if_gnt, mem_rw} !== 2'b10) begin
      errors++;
      $display("FAIL mis_fetch_cmd: gnt=%b rw=%b", if_gnt, mem_rw);
    end
    @(negedge clk);
    set_idle(); #1;
    checks++;
    if ({if_rvalid, if_err, if_rdata} !== {2'b11, 32'h0}) begin
      errors++;
      $display("FAIL mis_fetch_rsp: rv=%b err=%b data=%h",
        if_rvalid, if_err, if_rdata);
    end
  endtask

  task automatic test_reset_mid();
    logic want_if;
    poke(32'h200, 32'hA5A5_0F0F);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if_req = 1'b1; if_addr = 32'h100;
      d_cmd(1'b0, FUNC_W, 32'h200, 32'h0); #1;
      checks++;
      if (d_gnt !== 1'b1) begin
        errors++;
        $display("FAIL rm_pre i=%0d: d_gnt=%b want 1", i, d_gnt);
      end
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      reset = 1'b1; #1;
      checks++;
      if ({d_rvalid, if_rvalid, d_gnt, if_gnt, mem_rw} !== 5'b0) begin
        errors++;
        $display("FAIL rm_in_reset i=%0d: got %b want 0", i,
          {d_rvalid, if_rvalid, d_gnt, if_gnt, mem_rw});
      end
    end
    for (int k = 0; k <= SMAX + 1; k++) begin
      @(negedge clk);
      reset = 1'b0;
      if_req = (k <= SMAX); #1;
      want_if = (k == SMAX);
      checks++;
      if ({if_gnt, d_gnt} !== {want_if, !want_if}) begin
        errors++;
        $display("FAIL rm_gnt k=%0d: got %b%b want %b%b",
          k, if_gnt, d_gnt, want_if, !want_if);
      end
      if (k == 0) begin
        checks++;
        if ({d_rvalid, if_rvalid, d_err, if_err} !== 4'b0) begin
          errors++;
          $display("FAIL rm_first: rv/err=%b want 0",
            {d_rvalid, if_rvalid, d_err, if_err});
        end
      end
    end
    @(negedge clk);
    set_idle(); #1;
    checks++;
    if ({d_rvalid, d_rdata} !== {1'b1, 32'hA5A5_0F0F}) begin
      errors++;
      $display("FAIL rm_last: rv=%b data=%h", d_rvalid, d_rdata);
    end
  endtask

  task automatic test_random();
    logic        p_if, p_d;
    int          waited;
    logic        g_if, g_d, want_rw;
    logic [67:0] exp_rsp, nxt_rsp, act;
    logic [2:0]  f;
    p_if = 1'b0; p_d = 1'b0; waited = 0; exp_rsp = '0;
    for (int c = 0; c < NRND; c++) begin
      @(negedge clk);
      if (!p_if && c < NRND - 20 && $urandom_range(0, 99) < 50) begin
        p_if = 1'b1;
        if ($urandom_range(0, 9) == 0)
          if_addr = 32'($urandom_range(0, 4095));
        else
          if_addr = 32'($urandom_range(0, 1023)) << 2;
      end
      if (!p_d && c < NRND - 20 && $urandom_range(0, 99) < 60) begin
        p_d = 1'b1;
        case ($urandom_range(0, 4))
          0: f = FUNC_B;
          1: f = FUNC_H;
          2: f = FUNC_W;
          3: f = FUNC_BU;
          default: f = FUNC_HU;
        endcase
        d_rw = 1'($urandom_range(0, 1));
        if (d_rw) f[2] = 1'b0;
        d_func = f;
        d_addr = 32'($urandom_range(0, 4095));
        d_wdata = $urandom;
      end
      if_req = p_if; d_req = p_d;
      g_d  = p_d && !(p_if && waited >= SMAX);
      g_if = p_if && !g_d;
      want_rw = g_d && d_rw && !ref_mis(d_func, d_addr);
      #1;
      checks++;
      if ({if_gnt, d_gnt, mem_rw} !== {g_if, g_d, want_rw}) begin
        errors++;
        $display("FAIL rnd_gnt c=%0d: got %b%b%b want %b%b%b",
          c, if_gnt, d_gnt, mem_rw, g_if, g_d, want_rw);
      end
      act = {if_rvalid, if_err, if_rdata, d_rvalid, d_err, d_rdata};
      checks++;
      if (act !== exp_rsp) begin
        errors++;
        $display("FAIL rnd_rsp c=%0d: got %h want %h", c, act, exp_rsp);
      end
      nxt_rsp = '0;
      if (g_if) begin
        if (ref_mis(FUNC_W, if_addr))
          nxt_rsp[67:34] = {2'b11, 32'h0};
        else
          nxt_rsp[67:34] = {2'b10, ref_load(if_addr, FUNC_W)};
        p_if = 1'b0;
      end else if (g_d) begin
        if (ref_mis(d_func, d_addr)) begin
          nxt_rsp[33:0] = {2'b11, 32'h0};
        end else if (d_rw) begin
          ref_store(d_addr, d_func, d_wdata);
          nxt_rsp[33:0] = {2'b10, 32'h0};
        end else begin
          nxt_rsp[33:0] = {2'b10, ref_load(d_addr, d_func)};
        end
        p_d = 1'b0;
      end
      if (!if_req || g_if) waited = 0;
      else if (g_d) waited++;
      exp_rsp = nxt_rsp;
    end
    @(negedge clk);
    set_idle(); #1;
    act = {if_rvalid, if_err, if_rdata, d_rvalid, d_err, d_rdata};
    checks++;
    if (act !== exp_rsp || p_if || p_d) begin
      errors++;
      $display("FAIL rnd_drain: got %h want %h pend=%b%b",
        act, exp_rsp, p_if, p_d);
    end
  endtask

  initial begin
    logic [31:0] w;
    for (int i = 0; i < 1024; i++) begin
      w = $urandom;
      poke(32'(i) << 2, w);
    end
    poke(32'h100, 32'h0000_0013);
    test_reset();
    test_idle();
    test_fetch_only();
    test_contention();
    test_store_load();
    test_misaligned();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors",
      checks, errors);
    $finish;
  end

endmodule
